// File: rtl/bram_stream_writer.sv
// bram_stream_writer
//   Accepts one AXI-Stream frame per start pulse and writes each beat as a
//   full-width word into a BRAM port. Word addresses step up from base_addr
//   and wrap around at 2^C_ADDR_WIDTH. Every write is registered, so it
//   appears on the BRAM port one cycle after its beat is accepted.
//
// Optional build macro: BRAM_WR_DRAIN_EN
//   Defined   : if a frame overflows, the remaining beats are accepted and
//               discarded (DRAIN state) up to and including tlast.
//   Undefined : if a frame overflows, the FSM goes straight to DONE and the
//               remaining beats stay upstream.
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   start, base_addr frame start pulse and byte base address (used in IDLE only)
//   busy, done       not-IDLE flag; one-cycle frame-complete pulse
//   overflow         sticky; the frame was longer than C_MAX_WORDS
//   word_count       number of words written in the current/last frame
//   s_axis_*         AXI-Stream slave (tdata, tvalid, tready, tlast)
//   bram_*           BRAM master port (addr, din, we, en)
module bram_stream_writer #(
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_MAX_WORDS  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [C_ADDR_WIDTH-1:0]   base_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [16:0]               word_count,
    input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [C_ADDR_WIDTH-1:0]   bram_addr,
    output logic [C_DATA_WIDTH-1:0]   bram_din,
    output logic [C_DATA_WIDTH/8-1:0] bram_we,
    output logic                      bram_en
);

    localparam logic [C_ADDR_WIDTH-1:0] ADDR_STEP = C_ADDR_WIDTH'(C_DATA_WIDTH / 8);
    localparam logic [16:0]             LAST_IDX  = 17'(C_MAX_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
`ifdef BRAM_WR_DRAIN_EN
        S_DRAIN,
`endif
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;   // address for the next accepted beat
    logic [16:0]               count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic                      en_q, en_d;
    logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0]   din_q, din_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        en_d          = 1'b0;
        addr_d        = addr_q;
        din_d         = din_q;
        s_axis_tready = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wr_addr_d  = base_addr;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    en_d      = 1'b1;
                    addr_d    = wr_addr_q;
                    din_d     = s_axis_tdata;
                    wr_addr_d = wr_addr_q + ADDR_STEP;
                    count_d   = count_q + 17'd1;
                    if (s_axis_tlast) begin
                        state_d = S_DONE;
                    end else if (count_q == LAST_IDX) begin
                        // Word C_MAX_WORDS without tlast: frame is too long.
                        overflow_d = 1'b1;
`ifdef BRAM_WR_DRAIN_EN
                        state_d    = S_DRAIN;
`else
                        state_d    = S_DONE;
`endif
                    end
                end
            end
`ifdef BRAM_WR_DRAIN_EN
            S_DRAIN: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign overflow   = overflow_q;
    assign word_count = count_q;
    assign bram_en    = en_q;
    assign bram_we    = {(C_DATA_WIDTH/8){en_q}};
    assign bram_addr  = addr_q;
    assign bram_din   = din_q;

endmodule

// File: tb/tb_bram_stream_writer.sv
module tb_bram_stream_writer;

    localparam int unsigned MAXW = 4;
`ifdef BRAM_WR_DRAIN_EN
    localparam bit DRAIN = 1'b1;
`else
    localparam bit DRAIN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        busy, done, overflow;
    logic [16:0] word_count;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [31:0] bram_addr, bram_din;
    logic [3:0]  bram_we;
    logic        bram_en;

    bram_stream_writer #(
        .C_ADDR_WIDTH(32),
        .C_DATA_WIDTH(32),
        .C_MAX_WORDS (MAXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .word_count   (word_count),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .bram_we      (bram_we),
        .bram_en      (bram_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } wr_t;

    // Monitor: every write seen on the BRAM port and every done pulse.
    wr_t         wr_q[$];
    int unsigned done_total = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bram_en) wr_q.push_back('{addr: bram_addr, data: bram_din, we: bram_we});
            if (done) done_total = done_total + 1;
        end
    end

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    logic [31:0] beats[8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] data, input bit last, input int unsigned gaps);
        bit          acc;
        int unsigned budget;
        s_axis_tvalid = 1'b0;
        for (int unsigned g = 0; g < gaps; g++) begin
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 20) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk); #1;
            budget++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // gap_mode: 0 = back-to-back, 1 = one idle cycle before each beat, 2 = random
    task automatic run_frame(input logic [31:0] base, input int unsigned n,
                             input int unsigned gap_mode, input bit poke);
        int unsigned w0, d0, exp_n, sent, gaps, budget, got;
        logic [31:0] exp_addr;
        w0 = wr_q.size();
        d0 = done_total;
        exp_n = (n > MAXW) ? MAXW : n;
        sent  = DRAIN ? n : exp_n;

        base_addr = base;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = $urandom;

        for (int unsigned i = 0; i < sent; i++) begin
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
            send_beat(beats[i], (i == n - 1), gaps);
            if (poke && i == 0) begin
                // start and a new base while busy must be ignored
                start     = 1'b1;
                base_addr = base ^ 32'h0000_0F00;
                @(posedge clk); #1;
                start     = 1'b0;
            end
        end

        if (!DRAIN && n > MAXW) begin
            @(negedge clk);
            chk("tready_after_overflow", {63'd0, s_axis_tready}, 64'd0);
        end

        budget = 0;
        while (done_total == d0 && budget < 20) begin
            @(negedge clk); #1;
            budget++;
        end
        chk("done_seen", {63'd0, done_total != d0}, 64'd1);
        @(posedge clk);
        @(negedge clk); #1;

        got = wr_q.size() - w0;
        chk("write_count", 64'(got), 64'(exp_n));
        for (int unsigned i = 0; i < exp_n && i < got; i++) begin
            exp_addr = base + 32'(i * 4);
            chk("wr_addr", {32'd0, wr_q[w0 + i].addr}, {32'd0, exp_addr});
            chk("wr_data", {32'd0, wr_q[w0 + i].data}, {32'd0, beats[i]});
            chk("wr_we",   {60'd0, wr_q[w0 + i].we},   64'hF);
        end
        chk("done_pulses", 64'(done_total - d0), 64'd1);
        chk("overflow",    {63'd0, overflow}, {63'd0, n > MAXW});
        chk("word_count",  {47'd0, word_count}, 64'(exp_n));
        chk("busy_idle",   {63'd0, busy}, 64'd0);
        chk("tready_idle", {63'd0, s_axis_tready}, 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     {63'd0, busy}, 64'd0);
        chk({tag, "_done"},     {63'd0, done}, 64'd0);
        chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
        chk({tag, "_tready"},   {63'd0, s_axis_tready}, 64'd0);
        chk({tag, "_en"},       {63'd0, bram_en}, 64'd0);
        chk({tag, "_we"},       {60'd0, bram_we}, 64'd0);
        chk({tag, "_addr"},     {32'd0, bram_addr}, 64'd0);
        chk({tag, "_din"},      {32'd0, bram_din}, 64'd0);
        chk({tag, "_count"},    {47'd0, word_count}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned w0, d0, n;
        rst = 1'b1; start = 1'b0; base_addr = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic 4-beat frame, exactly C_MAX_WORDS long with tlast: no overflow
        for (int unsigned i = 0; i < 4; i++) beats[i] = 32'hA0 + i;
        run_frame(32'h0000_1000, 4, 0, 1'b0);
        // Same frame with tvalid toggling
        run_frame(32'h0000_1000, 4, 1, 1'b0);
        // Overflow: 6 beats, tlast on the 6th
        for (int unsigned i = 0; i < 6; i++) beats[i] = $urandom;
        run_frame(32'h0000_2000, 6, 0, 1'b0);
        // Address wrap
        beats[0] = 32'h1111_1111; beats[1] = 32'h2222_2222;
        run_frame(32'hFFFF_FFFC, 2, 0, 1'b0);
        // Start pulsed mid-frame is ignored
        for (int unsigned i = 0; i < 3; i++) beats[i] = $urandom;
        run_frame(32'h0000_3000, 3, 0, 1'b1);

        // Reset right after the second beat is accepted
        w0 = wr_q.size();
        base_addr = 32'h0000_4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_beat(32'hDEAD_0001, 1'b0, 0);
        send_beat(32'hDEAD_0002, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_writes", 64'(wr_q.size() - w0), 64'd1);
        @(posedge clk); #1;
        beats[0] = 32'h5A5A_0000;
        run_frame(32'h0000_5000, 1, 0, 1'b0);

        // Randomized frames
        for (int unsigned f = 0; f < 10; f++) begin
            n = $urandom_range(1, 6);
            for (int unsigned i = 0; i < 8; i++) beats[i] = $urandom;
            run_frame($urandom, n, 2, f[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
